// File: rtl/chan_mux_arb.sv
// chan_mux_arb: NCH-channel valid/ready multiplexer with a single registered output stage.
//   mode = 0 (DIRECT): channel chosen by sel; an out-of-range sel emits a FILL beat each
//                      time the output register loads, and fill_cnt counts those beats.
//   mode = 1 (RR):     round-robin among valid channels, starting after the last grant.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data/in_valid     flattened per-channel data (channel k at [k*WIDTH +: WIDTH]) and valids
//   in_ready             per-channel ready, combinational, at most one bit set
//   mode, sel            arbitration mode and DIRECT-mode channel select
//   out_data/out_valid   registered output beat
//   out_chan             source channel of out_data (the sel value for FILL beats)
//   out_ready            downstream ready
//   fill_cnt             saturating count of FILL beats emitted
module chan_mux_arb #(
  parameter int unsigned      NCH   = 9,
  parameter int unsigned      WIDTH = 16,
  parameter int unsigned      SEL_W = 4,
  parameter logic [WIDTH-1:0] FILL  = {WIDTH{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     out_chan,
  input  logic                 out_ready,
  output logic [15:0]          fill_cnt
);

  if (NCH < 2 || NCH > 16 || (2 ** SEL_W) < NCH) begin : g_param_check
    $error("chan_mux_arb: NCH must be 2..16 and fit in SEL_W bits");
  end

  // Valid bit of channel k; shifting avoids index-width mismatches for any NCH/SEL_W.
  function automatic logic valid_at(input logic [NCH-1:0] v, input int unsigned k);
    logic [31:0] s;
    s = 32'(v) >> k;
    return s[0];
  endfunction

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [15:0]      fill_q, fill_d;

  logic             load_en;
  logic             sel_ok;
  logic             fill_beat;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic [WIDTH-1:0] grant_data;

  assign load_en   = !valid_q || out_ready;
  assign sel_ok    = 32'(sel) < NCH;
  assign fill_beat = !mode && !sel_ok;

  // Round-robin search from ptr+1 upward, wrapping, ending at ptr itself.
  always_comb begin
    int unsigned idx;
    rr_grant = ptr_q;
    rr_found = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!rr_found && valid_at(in_valid, idx)) begin
        rr_found = 1'b1;
        rr_grant = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    if (mode) begin
      grant    = rr_grant;
      grant_ok = rr_found;
    end else begin
      grant    = sel;
      grant_ok = sel_ok && valid_at(in_valid, 32'(sel));
    end
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (32'(grant) == k) grant_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Reset gating keeps ready low while the register is held in reset (load_en is 1 then).
  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      in_ready[k] = rst_n && load_en && grant_ok && (32'(grant) == k);
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    if (load_en) begin
      if (fill_beat) begin
        data_d  = FILL;
        chan_d  = sel;
        valid_d = 1'b1;
        if (fill_q != 16'hFFFF) fill_d = fill_q + 16'd1;
      end else if (grant_ok) begin
        data_d  = grant_data;
        chan_d  = grant;
        valid_d = 1'b1;
        if (mode) ptr_d = grant;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      ptr_q   <= SEL_W'(NCH - 1);  // first RR grant lands on channel 0
      fill_q  <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_chan  = chan_q;
  assign fill_cnt  = fill_q;

endmodule

// File: doc/chan_mux_arb.md
CHAN_MUX_ARB -- requirements
Module: chan_mux_arb

Interface
REQ-001 Parameter NCH, default 9: number of input channels; legal range 2..16.
REQ-002 Parameter WIDTH, default 16: data width per channel, in bits.
REQ-003 Parameter SEL_W, default 4: width of sel and out_chan; the block SHALL require 2^SEL_W >= NCH.
REQ-004 Parameter FILL, default {WIDTH{1'b1}}: data value emitted for an out-of-range select.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_data  input  NCH*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 in_valid  input  NCH  per-channel valid.
REQ-009 in_ready  output  NCH  per-channel ready; combinational.
REQ-010 mode  input  1  0 = DIRECT (sel-steered), 1 = RR (round-robin arbitration).
REQ-011 sel  input  SEL_W  channel select, used in DIRECT mode only.
REQ-012 out_data  output  WIDTH  registered output data.
REQ-013 out_valid  output  1  registered output valid.
REQ-014 out_chan  output  SEL_W  registered index of the source of out_data (the sel value for FILL beats).
REQ-015 out_ready  input  1  downstream ready.
REQ-016 fill_cnt  output  16  count of FILL beats emitted; saturates at 16'hFFFF.

Function
REQ-017 The block SHALL hold a single output register; load_en = !out_valid || out_ready.
REQ-018 A transfer out SHALL occur on a rising edge where out_valid && out_ready are both 1.
REQ-019 A transfer in from channel k SHALL occur on a rising edge where in_valid[k] && in_ready[k] are both 1.
REQ-020 Input-to-output latency SHALL be 1 cycle: accepted data appears on out_data on the next cycle.
REQ-021 At most one in_ready bit SHALL be high in any cycle.
REQ-022 in_ready[k] SHALL equal load_en && (grant == k) && in_valid[k].
REQ-023 DIRECT mode, sel < NCH: grant = sel.
  - If in_valid[sel] && load_en: out_data <= channel sel, out_chan <= sel, out_valid <= 1.
  - Otherwise, if load_en: out_valid <= 0.
REQ-024 DIRECT mode, sel >= NCH: no in_ready is asserted.
  - If load_en: out_data <= FILL, out_chan <= sel, out_valid <= 1, fill_cnt increments.
REQ-025 RR mode: the block SHALL keep a pointer ptr (range 0..NCH-1) to the last granted channel.
  - grant = the first k with in_valid[k], searching ptr+1, ptr+2, ... with wrap from NCH-1 to 0, ending at ptr.
REQ-026 RR mode, on a transfer in: ptr <= grant; out_data, out_chan and out_valid SHALL load as in REQ-023.
REQ-027 RR mode, no in_valid set while load_en: out_valid <= 0 and ptr SHALL be unchanged.
REQ-028 In RR mode, sel SHALL be ignored and no FILL beats SHALL be produced.
REQ-029 While out_valid && !out_ready: out_data, out_chan and out_valid SHALL hold stable, all in_ready = 0, and ptr and fill_cnt SHALL be unchanged.
REQ-030 mode and sel SHALL be sampled combinationally each cycle; a mode change SHALL take effect in the same cycle and SHALL NOT modify ptr.
REQ-031 fill_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-032 Simultaneous transfer out and transfer in SHALL sustain one beat per cycle with no bubble.

Reset
REQ-033 When rst_n = 0, the following SHALL be forced immediately, independent of clk:
  - out_valid = 0, out_data = 0, out_chan = 0, fill_cnt = 0;
  - ptr = NCH-1, so the first RR grant goes to channel 0.
REQ-034 Reset asserted mid-transfer SHALL discard the held beat.
REQ-035 in_ready SHALL be 0 while rst_n = 0.
REQ-036 Normal operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-037 DIRECT mode: with NCH=9, WIDTH=16, out_ready=1 and channel k data = 16'h1000+k, sweep sel 0..8 with all valid -> next cycle out_data = 16'h1000+sel, out_chan = sel.
REQ-038 DIRECT mode, sel = 9..15 held 7 cycles, out_ready=1 -> out_data = 16'hFFFF, out_valid=1, fill_cnt = 7, in_ready = 0.
REQ-039 RR mode, all 9 channels valid, out_ready=1 -> grant order 0,1,...,8,0; channels 2 and 5 only valid -> alternating 2,5,2,5.
REQ-040 Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_data and out_chan stable, in_ready = 0; out_ready=1 -> one beat per cycle resumes, no loss or duplication.
REQ-041 Reset mid-stream: rst_n low between clock edges -> out_valid = 0 immediately; after release in RR mode with all valid, first grant = channel 0.
REQ-042 Saturation: force 65540 FILL beats -> fill_cnt = 16'hFFFF and stays there.
